// File: rtl/logic_gate_pipe.sv
// rtl/logic_gate_pipe.sv - registered bitwise gate unit with multi-beat NOR-accumulate
// Single-entry output register with valid/ready handshakes on the operand and result sides.
module logic_gate_pipe #(
   parameter int WIDTH = 8,
   parameter int BEATS = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             y_zero,
   output logic             acc_busy
);

   localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

   typedef enum logic {
      ST_IDLE,
      ST_ACC
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic             out_valid_q, out_valid_d;
   logic             y_zero_q, y_zero_d;
   logic             acc_busy_q, acc_busy_d;

   logic             slot_free;
   logic             last_beat;
   logic             in_xfer;
   logic             out_xfer;
   logic             load;
   logic [WIDTH-1:0] gate_res;
   logic [WIDTH-1:0] ab_or;

   assign slot_free = !out_valid_q || out_ready;
   assign last_beat = (cnt_q == LAST_BEAT);
   assign ab_or     = a | b;

   // Non-final accumulate beats never produce a result, so they need no free output slot.
   assign in_ready  = (state_q == ST_ACC && !last_beat) ? 1'b1 : slot_free;
   assign in_xfer   = in_valid && in_ready;
   assign out_xfer  = out_valid_q && out_ready;

   always_comb begin
      gate_res = '0;
      case (op)
         3'b000:  gate_res = a & b;
         3'b001:  gate_res = a | b;
         3'b010:  gate_res = ~(a & b);
         3'b011:  gate_res = ~(a | b);
         3'b100:  gate_res = a ^ b;
         3'b101:  gate_res = ~(a ^ b);
         3'b110:  gate_res = ~a;
         default: gate_res = '0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      y_d        = y_q;
      acc_busy_d = acc_busy_q;
      load       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_xfer) begin
               if (op == 3'b111) begin
                  acc_d      = ab_or;
                  cnt_d      = CW'(1);
                  state_d    = ST_ACC;
                  acc_busy_d = 1'b1;
               end else begin
                  y_d  = gate_res;
                  load = 1'b1;
               end
            end
         end
         ST_ACC: begin
            if (in_xfer) begin
               if (last_beat) begin
                  y_d        = ~(acc_q | ab_or);
                  load       = 1'b1;
                  cnt_d      = '0;
                  acc_d      = '0;
                  state_d    = ST_IDLE;
                  acc_busy_d = 1'b0;
               end else begin
                  acc_d = acc_q | ab_or;
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
      endcase
      out_valid_d = load ? 1'b1 : (out_xfer ? 1'b0 : out_valid_q);
      y_zero_d    = ~|y_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         y_q         <= '0;
         out_valid_q <= 1'b0;
         y_zero_q    <= 1'b1;
         acc_busy_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         y_q         <= y_d;
         out_valid_q <= out_valid_d;
         y_zero_q    <= y_zero_d;
         acc_busy_q  <= acc_busy_d;
      end
   end

   assign out_valid = out_valid_q;
   assign y         = y_q;
   assign y_zero    = y_zero_q;
   assign acc_busy  = acc_busy_q;

endmodule
